// File: rtl/branch_predict_table.sv
// branch_predict_table
//   Direct-mapped branch target table for a two-slot fetch stage. Each entry
//   is 16 bits: [15] valid, [14:13] 2-bit saturating counter, [12:0] target.
//   After reset the table sweeps every entry to zero (busy=1), then serves
//   predictions until the next reset.
//
// Ports
//   CLK            : clock, rising edge
//   RST            : asynchronous active-high reset
//   pcF1, pcF2     : fetch PCs for slot 1 / slot 2 (index = pc[IDX_W+1:2])
//   stall          : holds the registered read results
//   predict_wen    : entry write strobe (ignored while clearing)
//   predict_w_addr : entry index to write
//   predict_w_data : entry value to write
//   pred_taken1/2  : slot predicted taken (valid & counter[1])
//   pred_target1/2 : predicted target, zero when not taken
//   busy           : clear sweep in progress; predictions forced to zero
module branch_predict_table #(
  parameter int IDX_W = 11,
  parameter int PC_W  = 13
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PC_W-1:0]  pcF1,
  input  logic [PC_W-1:0]  pcF2,
  input  logic             stall,
  input  logic             predict_wen,
  input  logic [IDX_W-1:0] predict_w_addr,
  input  logic [15:0]      predict_w_data,
  output logic             pred_taken1,
  output logic [12:0]      pred_target1,
  output logic             pred_taken2,
  output logic [12:0]      pred_target2,
  output logic             busy
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [15:0]      r_mem [DEPTH];
  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [15:0]      r_rd1;
  logic [15:0]      r_rd2;

  logic             w_clearing;
  logic             w_wen;
  logic [IDX_W-1:0] w_waddr;
  logic [15:0]      w_wdata;
  logic [IDX_W-1:0] w_idx1;
  logic [IDX_W-1:0] w_idx2;
  logic [15:0]      w_rd1_next;
  logic [15:0]      w_rd2_next;
  logic             w_take1;
  logic             w_take2;
  logic             w_unused;

  assign w_clearing = (r_state == S_CLEAR);

  // The sweep owns the write port while clearing; external writes are dropped.
  assign w_wen   = w_clearing | predict_wen;
  assign w_waddr = w_clearing ? r_cnt : predict_w_addr;
  assign w_wdata = w_clearing ? 16'h0000 : predict_w_data;

  assign w_idx1 = pcF1[IDX_W+1:2];
  assign w_idx2 = pcF2[IDX_W+1:2];

  // Write-first bypass; also covers the sweep so no stale entry is ever latched.
  assign w_rd1_next = (w_wen && (w_waddr == w_idx1)) ? w_wdata : r_mem[w_idx1];
  assign w_rd2_next = (w_wen && (w_waddr == w_idx2)) ? w_wdata : r_mem[w_idx2];

  // Storage carries no reset; the sweep zeroes it before READY.
  always_ff @(posedge CLK) begin
    if (w_wen) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else if (w_clearing) begin
      if (r_cnt == {IDX_W{1'b1}}) begin
        r_state <= S_READY;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else if (!stall) begin
      r_rd1 <= w_rd1_next;
      r_rd2 <= w_rd2_next;
    end
  end

  assign w_take1 = !w_clearing && r_rd1[15] && r_rd1[14];
  assign w_take2 = !w_clearing && r_rd2[15] && r_rd2[14];

  assign pred_taken1  = w_take1;
  assign pred_target1 = w_take1 ? r_rd1[12:0] : 13'h0000;
  assign pred_taken2  = w_take2;
  assign pred_target2 = w_take2 ? r_rd2[12:0] : 13'h0000;
  assign busy         = w_clearing;

  // Byte-offset/upper PC bits and the counter LSB do not affect the prediction.
  assign w_unused = ^{pcF1, pcF2, r_rd1[13], r_rd2[13]};

endmodule
